// File: rtl/ped_crossing.sv
// Pedestrian crossing controller slaved to the vehicle light controller.
// Grants WALK only on a fresh pure-red phase and aborts if red is lost.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no request, DON'T WALK steady
// WAIT  | request accepted, waiting for the next pure-red start
// WALK  | WALK lamp on for WALK_T cycles
// CLEAR | DON'T WALK flashing for FLASH_T cycles
module ped_crossing #(
    parameter int WALK_T     = 10,
    parameter int FLASH_T    = 6,
    parameter int FLASH_HALF = 2,
    parameter int DB_T       = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic red,
    input  logic yellow,
    input  logic green,
    input  logic btn,
    output logic walk,
    output logic dont_walk,
    output logic ped_wait,
    output logic conflict
);

    localparam int MAX_WF = (WALK_T > FLASH_T) ? WALK_T : FLASH_T;
    localparam int MAX_T  = (MAX_WF > DB_T) ? MAX_WF : DB_T;
    localparam int CNT_W  = $clog2(MAX_T) + 1;
    localparam int FH_W   = $clog2(FLASH_HALF) + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_WALK  = 2'd2,
        S_CLEAR = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [FH_W-1:0]    fh_q, fh_d;
    logic               ph_q, ph_d;
    logic               pending_q, pending_d;
    logic               pure_red_q;
    logic               btn_s1_q, btn_s2_q;
    logic               db_level_q, db_level_d;
    logic [CNT_W-1:0]   db_cnt_q, db_cnt_d;
    logic               walk_q, walk_d;
    logic               dont_walk_q, dont_walk_d;
    logic               ped_wait_q, ped_wait_d;
    logic               conflict_q, conflict_d;

    logic pure_red;
    logic red_start;
    logic lamp_clash;
    logic press;

    always_comb begin
        pure_red   = red & ~yellow & ~green;
        red_start  = pure_red & ~pure_red_q;
        lamp_clash = green & (red | yellow);
    end

    // Level flips on the DB_T-th consecutive differing sample; press is
    // taken from the next level so the FSM sees it on the flip edge.
    always_comb begin
        db_level_d = db_level_q;
        db_cnt_d   = '0;
        if (btn_s2_q != db_level_q) begin
            if (db_cnt_q == CNT_W'(DB_T - 1)) begin
                db_level_d = btn_s2_q;
            end else begin
                db_cnt_d = db_cnt_q + CNT_W'(1);
            end
        end
        press = db_level_d & ~db_level_q;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        fh_d      = fh_q;
        ph_d      = ph_q;
        pending_d = pending_q;

        case (state_q)
            S_IDLE: begin
                if (press) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (red_start) begin
                    state_d = S_WALK;
                    cnt_d   = CNT_W'(WALK_T - 1);
                end
            end
            S_WALK: begin
                if (press) begin
                    pending_d = 1'b1;
                end
                if (!pure_red) begin
                    state_d   = (pending_q | press) ? S_WAIT : S_IDLE;
                    pending_d = 1'b0;
                end else if (cnt_q == '0) begin
                    state_d = S_CLEAR;
                    cnt_d   = CNT_W'(FLASH_T - 1);
                    fh_d    = FH_W'(FLASH_HALF - 1);
                    ph_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_CLEAR: begin
                if (press) begin
                    pending_d = 1'b1;
                end
                if (fh_q == '0) begin
                    fh_d = FH_W'(FLASH_HALF - 1);
                    ph_d = ~ph_q;
                end else begin
                    fh_d = fh_q - FH_W'(1);
                end
                if (!pure_red || cnt_q == '0) begin
                    state_d   = (pending_q | press) ? S_WAIT : S_IDLE;
                    pending_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d   = S_IDLE;
                pending_d = 1'b0;
            end
        endcase
    end

    // Lamps follow the current state one register later; loss of pure red
    // forces DON'T WALK immediately rather than waiting for the state change.
    always_comb begin
        walk_d      = 1'b0;
        dont_walk_d = 1'b1;
        ped_wait_d  = 1'b0;
        conflict_d  = conflict_q | lamp_clash | ((state_q == S_WALK) & ~pure_red);

        case (state_q)
            S_IDLE: begin
                ped_wait_d = 1'b0;
            end
            S_WAIT: begin
                ped_wait_d = 1'b1;
            end
            S_WALK: begin
                walk_d      = pure_red;
                dont_walk_d = ~pure_red;
                ped_wait_d  = pending_q;
            end
            S_CLEAR: begin
                dont_walk_d = ph_q | ~pure_red;
                ped_wait_d  = pending_q;
            end
            default: begin
                ped_wait_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            fh_q        <= '0;
            ph_q        <= 1'b1;
            pending_q   <= 1'b0;
            pure_red_q  <= 1'b0;
            btn_s1_q    <= 1'b0;
            btn_s2_q    <= 1'b0;
            db_level_q  <= 1'b0;
            db_cnt_q    <= '0;
            walk_q      <= 1'b0;
            dont_walk_q <= 1'b1;
            ped_wait_q  <= 1'b0;
            conflict_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fh_q        <= fh_d;
            ph_q        <= ph_d;
            pending_q   <= pending_d;
            pure_red_q  <= pure_red;
            btn_s1_q    <= btn;
            btn_s2_q    <= btn_s1_q;
            db_level_q  <= db_level_d;
            db_cnt_q    <= db_cnt_d;
            walk_q      <= walk_d;
            dont_walk_q <= dont_walk_d;
            ped_wait_q  <= ped_wait_d;
            conflict_q  <= conflict_d;
        end
    end

    assign walk      = walk_q;
    assign dont_walk = dont_walk_q;
    assign ped_wait  = ped_wait_q;
    assign conflict  = conflict_q;

endmodule

// File: tb/tb_ped_crossing.sv
// Scoreboard bench for ped_crossing: stimulus pushes the hand-computed lamp
// vector {walk, dont_walk, ped_wait, conflict} expected after each edge.
module tb_ped_crossing;

    logic clk = 1'b0;
    logic rst;
    logic red, yellow, green, btn;
    logic walk, dont_walk, ped_wait, conflict;

    ped_crossing #(
        .WALK_T     (10),
        .FLASH_T    (6),
        .FLASH_HALF (2),
        .DB_T       (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .red       (red),
        .yellow    (yellow),
        .green     (green),
        .btn       (btn),
        .walk      (walk),
        .dont_walk (dont_walk),
        .ped_wait  (ped_wait),
        .conflict  (conflict)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [3:0] mask;
        logic [3:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    exp_t       mon_e;
    logic [3:0] mon_got;

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e   = sb.pop_front();
            mon_got = {walk, dont_walk, ped_wait, conflict};
            n_tests++;
            if ((mon_got & mon_e.mask) !== (mon_e.exp & mon_e.mask)) begin
                n_fail++;
                $display("FAIL %s: got w/dw/pw/c=%b expected %b (mask %b) at %0t",
                         mon_e.name, mon_got, mon_e.exp, mon_e.mask, $time);
            end
            n_tests++;
            if (walk === 1'b1 && dont_walk === 1'b1) begin
                n_fail++;
                $display("FAIL lamp_excl: walk=%b dont_walk=%b required not both 1 at %0t",
                         walk, dont_walk, $time);
            end
        end
    end

    task automatic step(input string name, input logic [3:0] mask, input logic [3:0] exp);
        exp_t e;
        @(posedge clk);
        e.name = name;
        e.mask = mask;
        e.exp  = exp;
        sb.push_back(e);
        #1;
    endtask

    task automatic lamps(input logic r, input logic y, input logic g);
        red    = r;
        yellow = y;
        green  = g;
    endtask

    // Clean 6-cycle press from IDLE: WAIT is reached on the 6th edge and
    // ped_wait shows on the 7th (2 sync + 4 debounce + 1 output register).
    task automatic press(input string name, input logic c);
        btn = 1'b1;
        for (int i = 0; i < 6; i++) step(name, 4'b1111, {3'b010, c});
        btn = 1'b0;
        step(name, 4'b1111, {3'b011, c});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [5:0] clear_pat;

    initial begin
        rst = 1'b1;
        btn = 1'b0;
        lamps(1'b0, 1'b0, 1'b1);
        step("reset", 4'b1111, 4'b0100);
        step("reset", 4'b1111, 4'b0100);
        rst = 1'b0;

        // Basic service: press on green, then pure red.
        press("basic_press", 1'b0);
        step("basic_wait", 4'b1111, 4'b0110);
        step("basic_wait", 4'b1111, 4'b0110);
        lamps(1'b1, 1'b0, 1'b0);
        step("basic_red_start", 4'b1111, 4'b0110);
        for (int i = 0; i < 10; i++) step("basic_walk", 4'b1111, 4'b1000);
        clear_pat = 6'b110011;
        for (int i = 5; i >= 0; i--) step("basic_clear", 4'b1111, {1'b0, clear_pat[i], 2'b00});
        step("basic_idle", 4'b1111, 4'b0100);
        step("basic_idle", 4'b1111, 4'b0100);

        // Debounce: a 3-cycle glitch must not register.
        lamps(1'b0, 1'b0, 1'b1);
        step("glitch_green", 4'b1111, 4'b0100);
        btn = 1'b1;
        for (int i = 0; i < 3; i++) step("glitch", 4'b1111, 4'b0100);
        btn = 1'b0;
        for (int i = 0; i < 8; i++) step("glitch_none", 4'b1111, 4'b0100);

        // Abort: red lost 5 cycles into WALK.
        press("abort_press", 1'b0);
        lamps(1'b1, 1'b0, 1'b0);
        step("abort_red_start", 4'b1111, 4'b0110);
        for (int i = 0; i < 5; i++) step("abort_walk", 4'b1111, 4'b1000);
        lamps(1'b0, 1'b0, 1'b1);
        step("abort", 4'b1111, 4'b0101);
        for (int i = 0; i < 4; i++) step("conflict_sticky", 4'b1111, 4'b0101);
        rst = 1'b1;
        step("rst_clears_conflict", 4'b1111, 4'b0100);
        rst = 1'b0;

        // Illegal lamp combination while idle.
        lamps(1'b1, 1'b0, 1'b1);
        step("clash", 4'b1111, 4'b0101);
        lamps(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step("clash_sticky", 4'b1111, 4'b0101);
        rst = 1'b1;
        step("rst_after_clash", 4'b1111, 4'b0100);
        rst = 1'b0;

        // Re-request during CLEAR goes straight to WAIT.
        press("rereq_press", 1'b0);
        lamps(1'b1, 1'b0, 1'b0);
        step("rereq_red_start", 4'b1111, 4'b0110);
        for (int i = 0; i < 6; i++) step("rereq_walk", 4'b1111, 4'b1000);
        btn = 1'b1;
        for (int i = 0; i < 4; i++) step("rereq_walk", 4'b1111, 4'b1000);
        step("rereq_clear", 4'b1111, 4'b0100);
        step("rereq_clear", 4'b1111, 4'b0100);
        btn = 1'b0;
        step("rereq_clear_pend", 4'b1111, 4'b0010);
        step("rereq_clear_pend", 4'b1111, 4'b0010);
        step("rereq_clear_pend", 4'b1111, 4'b0110);
        step("rereq_clear_pend", 4'b1111, 4'b0110);
        step("rereq_wait", 4'b1111, 4'b0110);
        step("rereq_wait_red_steady", 4'b1111, 4'b0110);
        lamps(1'b0, 1'b1, 1'b0);
        step("rereq_wait_yellow", 4'b1111, 4'b0110);
        lamps(1'b1, 1'b0, 1'b0);
        step("rerun_red_start", 4'b1111, 4'b0110);
        step("rerun_walk", 4'b1111, 4'b1000);

        // Press during WALK, then reset in CLEAR with red held.
        btn = 1'b1;
        for (int i = 0; i < 6; i++) step("rerun_walk", 4'b1111, 4'b1000);
        btn = 1'b0;
        for (int i = 0; i < 3; i++) step("rerun_walk_pend", 4'b1111, 4'b1010);
        step("rerun_clear_pend", 4'b1111, 4'b0110);
        step("rerun_clear_pend", 4'b1111, 4'b0110);
        step("rerun_clear_pend", 4'b1111, 4'b0010);
        rst = 1'b1;
        step("rst_mid_clear", 4'b1111, 4'b0100);
        rst = 1'b0;
        step("post_rst_idle", 4'b1111, 4'b0100);
        step("post_rst_idle", 4'b1111, 4'b0100);
        press("post_rst_press", 1'b0);
        for (int i = 0; i < 3; i++) step("post_rst_no_walk", 4'b1111, 4'b0110);
        lamps(1'b0, 1'b1, 1'b0);
        step("post_rst_yellow", 4'b1111, 4'b0110);
        lamps(1'b1, 1'b0, 1'b0);
        step("post_rst_red_start", 4'b1111, 4'b0110);
        step("post_rst_walk", 4'b1111, 4'b1000);

        @(posedge clk);
        @(negedge clk);
        #1;
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
